// File: rtl/line_tracker_fsm.sv
// Line tracker decision stage: filters the {L,M,R} IR sensors and sequences
// start countdown, line following, intersection routing, line loss and stop.
module line_tracker_fsm #(
    parameter int unsigned FILTER_LEN  = 16,
    parameter int unsigned START_DELAY = 100_000_000,
    parameter int unsigned LOST_LEN    = 50_000_000,
    parameter int unsigned TURN_MIN    = 10_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] sensor,
    input  logic [1:0] route,
    output logic [4:0] mode,
    output logic [4:0] lastMode,
    output logic [3:0] node_cnt
);

    localparam logic [4:0] IDLE              = 5'd0;
    localparam logic [4:0] START             = 5'd1;
    localparam logic [4:0] COUNT             = 5'd2;
    localparam logic [4:0] STRAIGHT          = 5'd3;
    localparam logic [4:0] CHOOSE            = 5'd4;
    localparam logic [4:0] TURN_STRAIGHT     = 5'd5;
    localparam logic [4:0] TURN_LEFT         = 5'd6;
    localparam logic [4:0] TURN_RIGHT        = 5'd7;
    localparam logic [4:0] TURN_LITTLE_LEFT  = 5'd8;
    localparam logic [4:0] TURN_LITTLE_RIGHT = 5'd9;
    localparam logic [4:0] STOP              = 5'd30;
    localparam logic [4:0] ERROR             = 5'd31;

    localparam logic [26:0] CNT_MAX    = '1;
    localparam logic [26:0] FILT_THR   = 27'(FILTER_LEN);
    localparam logic [26:0] START_LAST = 27'(START_DELAY - 1);
    localparam logic [26:0] LOST_THR   = 27'(LOST_LEN);
    localparam logic [26:0] TURN_THR   = 27'(TURN_MIN);

    function automatic logic [26:0] sat_inc(input logic [26:0] v);
        return (v == CNT_MAX) ? v : v + 27'd1;
    endfunction

    logic [4:0]  mode_q, mode_d, last_q, last_d;
    logic [3:0]  node_q, node_d;
    logic [2:0]  raw_q, pat_q, pat_d;
    logic [26:0] run_q, run_d, phase_q, phase_d, lost_q, lost_d;
    logic        running;

    assign mode     = mode_q;
    assign lastMode = last_q;
    assign node_cnt = node_q;

    always_comb begin
        run_d = (sensor == raw_q) ? sat_inc(run_q) : '0;
        pat_d = (run_d >= FILT_THR) ? sensor : pat_q;

        running = !(mode_q inside {IDLE, STOP, ERROR});
        lost_d  = (running && pat_q == 3'b000) ? sat_inc(lost_q) : '0;

        mode_d  = mode_q;
        phase_d = '0;
        node_d  = node_q;

        case (mode_q)
            IDLE:  if (start) mode_d = START;
            START: mode_d = COUNT;
            COUNT: begin
                if (phase_q >= START_LAST) mode_d = STRAIGHT;
                else phase_d = sat_inc(phase_q);
            end
            STRAIGHT, TURN_LITTLE_LEFT, TURN_LITTLE_RIGHT: begin
                // 101 and 000 fall through to default and hold the mode
                case (pat_q)
                    3'b010:  mode_d = STRAIGHT;
                    3'b110:  mode_d = TURN_LITTLE_LEFT;
                    3'b011:  mode_d = TURN_LITTLE_RIGHT;
                    3'b100:  mode_d = TURN_LEFT;
                    3'b001:  mode_d = TURN_RIGHT;
                    3'b111:  mode_d = CHOOSE;
                    default: mode_d = mode_q;
                endcase
            end
            CHOOSE: begin
                if (pat_q != 3'b111) begin
                    case (route)
                        2'b00:   mode_d = TURN_STRAIGHT;
                        2'b01:   mode_d = TURN_LEFT;
                        2'b10:   mode_d = TURN_RIGHT;
                        default: mode_d = STOP;
                    endcase
                end
            end
            TURN_STRAIGHT, TURN_LEFT, TURN_RIGHT: begin
                phase_d = sat_inc(phase_q);
                if (phase_q >= TURN_THR && pat_q == 3'b010) mode_d = STRAIGHT;
            end
            STOP, ERROR: begin
                if (start) begin
                    mode_d = START;
                    node_d = '0;
                end
            end
            default: mode_d = IDLE;
        endcase

        // Line-loss timeout wins over any pattern-driven transition
        if (running && lost_d >= LOST_THR) mode_d = ERROR;

        if (mode_d == CHOOSE && mode_q != CHOOSE) node_d = node_q + 4'd1;

        last_d = (mode_d != mode_q) ? mode_q : 5'd0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q  <= IDLE;
            last_q  <= 5'd0;
            node_q  <= 4'd0;
            raw_q   <= 3'b010;
            pat_q   <= 3'b010;
            run_q   <= '0;
            phase_q <= '0;
            lost_q  <= '0;
        end else begin
            mode_q  <= mode_d;
            last_q  <= last_d;
            node_q  <= node_d;
            raw_q   <= sensor;
            pat_q   <= pat_d;
            run_q   <= run_d;
            phase_q <= phase_d;
            lost_q  <= lost_d;
        end
    end

endmodule

// File: tb/tb_line_tracker_fsm.sv
// Directed bench for line_tracker_fsm with short timing parameters.
module tb_line_tracker_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] sensor;
    logic [1:0] route;
    logic [4:0] mode;
    logic [4:0] lastMode;
    logic [3:0] node_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int n;
    logic glitch;

    line_tracker_fsm #(
        .FILTER_LEN (4),
        .START_DELAY(20),
        .LOST_LEN   (30),
        .TURN_MIN   (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .sensor  (sensor),
        .route   (route),
        .mode    (mode),
        .lastMode(lastMode),
        .node_cnt(node_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance to the negedge where mode == m, or give up after budget cycles
    task automatic wait_mode(input logic [4:0] m, input int budget, output int cycles);
        cycles = 0;
        while (mode !== m && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; start = 1'b0; sensor = 3'b010; route = 2'b00;
        repeat (3) @(negedge clk);
        check_eq("rst_mode", mode, 0);
        check_eq("rst_last", lastMode, 0);
        check_eq("rst_node", node_cnt, 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("idle_hold", mode, 0);

        // 1. start sequence
        pulse_start();
        check_eq("t1_start", mode, 1);
        check_eq("t1_start_last", lastMode, 0);
        @(negedge clk);
        check_eq("t1_count", mode, 2);
        check_eq("t1_count_last", lastMode, 1);
        @(negedge clk);
        check_eq("t1_count_last0", lastMode, 0);
        pulse_start();
        check_eq("t1_start_ignored", mode, 2);
        wait_mode(3, 40, n);
        check_eq("t1_straight", mode, 3);
        check_eq("t1_count_len", n, 18);
        check_eq("t1_straight_last", lastMode, 2);
        @(negedge clk);
        check_eq("t1_last_clear", lastMode, 0);

        // 2. filter rejection, then small corrections
        glitch = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sensor = i[0] ? 3'b010 : 3'b110;
            repeat (2) @(negedge clk);
            if (mode !== 5'd3) glitch = 1'b1;
        end
        check_eq("t2_reject", {31'd0, glitch}, 0);
        sensor = 3'b110;
        wait_mode(8, 12, n);
        check_eq("t2_little_left", mode, 8);
        check_eq("t2_filter_lat", n, 6);
        sensor = 3'b011;
        wait_mode(9, 12, n);
        check_eq("t2_little_right", mode, 9);

        // 3. intersection with left turn
        route = 2'b01; sensor = 3'b111;
        wait_mode(4, 12, n);
        check_eq("t3_choose", mode, 4);
        check_eq("t3_node", node_cnt, 1);
        check_eq("t3_choose_last", lastMode, 9);
        sensor = 3'b100;
        repeat (3) @(negedge clk);
        check_eq("t3_choose_hold", mode, 4);
        wait_mode(6, 12, n);
        check_eq("t3_turn_left", mode, 6);
        sensor = 3'b010;
        repeat (7) @(negedge clk);
        check_eq("t3_turn_min_hold", mode, 6);
        wait_mode(3, 12, n);
        check_eq("t3_exit", mode, 3);
        check_eq("t3_exit_time", n, 2);
        check_eq("t3_exit_last", lastMode, 6);
        @(negedge clk);
        check_eq("t3_exit_last0", lastMode, 0);

        // 4. intersection with stop
        route = 2'b11; sensor = 3'b111;
        wait_mode(4, 12, n);
        check_eq("t4_node", node_cnt, 2);
        sensor = 3'b010;
        wait_mode(30, 12, n);
        check_eq("t4_stop", mode, 30);
        check_eq("t4_stop_last", lastMode, 4);
        sensor = 3'b000;
        repeat (40) @(negedge clk);
        check_eq("t4_stop_hold_000", mode, 30);
        sensor = 3'b100;
        repeat (8) @(negedge clk);
        check_eq("t4_stop_hold_100", mode, 30);
        sensor = 3'b010;
        repeat (6) @(negedge clk);
        pulse_start();
        check_eq("t4_restart", mode, 1);
        check_eq("t4_node_clr", node_cnt, 0);
        wait_mode(3, 40, n);
        check_eq("t4_straight", mode, 3);

        // 5. line loss
        sensor = 3'b000;
        repeat (20) @(negedge clk);
        sensor = 3'b010;
        repeat (40) @(negedge clk);
        check_eq("t5_no_error", mode, 3);
        sensor = 3'b000;
        wait_mode(31, 60, n);
        check_eq("t5_error", mode, 31);
        check_eq("t5_error_time", n, 35);
        check_eq("t5_error_last", lastMode, 3);

        // 6. reset mid-turn, then node counter wrap
        sensor = 3'b010;
        repeat (6) @(negedge clk);
        pulse_start();
        check_eq("t6_restart", mode, 1);
        wait_mode(3, 40, n);
        route = 2'b10; sensor = 3'b111;
        wait_mode(4, 12, n);
        sensor = 3'b001;
        wait_mode(7, 12, n);
        check_eq("t6_turn_right", mode, 7);
        check_eq("t6_node", node_cnt, 1);
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check_eq("t6_rst_mode", mode, 0);
        check_eq("t6_rst_last", lastMode, 0);
        check_eq("t6_rst_node", node_cnt, 0);
        @(negedge clk);
        rst = 1'b1; sensor = 3'b010;
        repeat (10) @(negedge clk);
        check_eq("t6_idle_wait", mode, 0);
        pulse_start();
        wait_mode(3, 40, n);
        check_eq("t6_straight", mode, 3);
        route = 2'b00;
        for (int k = 1; k <= 16; k++) begin
            sensor = 3'b111;
            wait_mode(4, 12, n);
            sensor = 3'b010;
            wait_mode(5, 12, n);
            wait_mode(3, 20, n);
            check_eq("t6_node_wrap", node_cnt, k % 16);
        end
        check_eq("t6_final_mode", mode, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/line_tracker_fsm.md
Name: line_tracker_fsm

Overview:
- Upstream decision stage of the motor controller.
- Filters the three IR line sensors and runs the start and tracking state machine.
- Produces the 5-bit mode code and a one-cycle lastMode exit marker, which the downstream motor block consumes directly.
- Handles start countdown, line following, intersection route choice, line loss and stop.

Parameters:
FILTER_LEN, 16, consecutive identical raw sensor samples required before the filtered pattern updates (1..2^27-1)
START_DELAY, 100_000_000, cycles spent in COUNT before STRAIGHT (1 s at 100 MHz)
LOST_LEN, 50_000_000, consecutive cycles of filtered pattern 000 tolerated before ERROR
TURN_MIN, 10_000_000, minimum cycles held in TURN_LEFT/TURN_RIGHT/TURN_STRAIGHT before exit is allowed

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  asynchronous reset, active-low (asserted when 0)
start  in  1  synchronous single-cycle start pulse (already debounced)
sensor  in  3  raw IR bits {L,M,R}; 1 = black line seen
route  in  2  action at the current intersection: 00 straight, 01 left, 10 right, 11 stop
mode  out  5  current mode code
lastMode  out  5  mode just departed; valid for one cycle, otherwise 0
node_cnt  out  4  intersections passed, wraps 15->0

Behaviour:
- Mode codes: IDLE 0, START 1, COUNT 2, STRAIGHT 3, CHOOSE 4, TURN_STRAIGHT 5, TURN_LEFT 6, TURN_RIGHT 7, TURN_LITTLE_LEFT 8, TURN_LITTLE_RIGHT 9, STOP 30, ERROR 31. Other codes are never driven.
- Reset (rst=0), asynchronous, all outputs and state registers:
  - mode=IDLE, lastMode=0, node_cnt=0.
  - Filtered pattern=010; filter, phase and lost counters=0.
  - Reset mid-operation aborts immediately; no exit marker is produced.
- Filter:
  - The raw sample is compared with the previous raw sample each cycle. A mismatch clears the run counter.
  - When the run reaches FILTER_LEN, the filtered pattern P takes the raw value.
  - All tracking decisions use P only.
  - Counters are 27 bits and saturate.
- Mode output is registered. A transition decided at edge n is visible after edge n.
- lastMode:
  - On any cycle where mode changes, lastMode is the old mode for exactly that one cycle; otherwise lastMode is 0.
  - Consequence: a TURN_LEFT->STRAIGHT exit yields lastMode=6 for one cycle.
- IDLE: start -> START.
- START: unconditional -> COUNT after 1 cycle. The phase counter is cleared.
- COUNT: phase counter increments. At START_DELAY-1 -> STRAIGHT. A start pulse during COUNT is ignored.
- Tracking states (STRAIGHT, TURN_LITTLE_LEFT, TURN_LITTLE_RIGHT), next mode by P:
  - 010 -> STRAIGHT
  - 110 -> TURN_LITTLE_LEFT
  - 011 -> TURN_LITTLE_RIGHT
  - 100 -> TURN_LEFT
  - 001 -> TURN_RIGHT
  - 111 -> CHOOSE
  - 101 -> hold current mode
  - 000 -> hold current mode; the lost counter increments.
- Line loss:
  - The lost counter runs during 000 in all running modes except STOP/ERROR. Any non-000 P clears it.
  - At LOST_LEN -> ERROR from any running mode, overriding all other transitions.
- CHOOSE:
  - On entry, node_cnt increments.
  - Held while P=111.
  - On the first P!=111, route is sampled that cycle: 00 -> TURN_STRAIGHT, 01 -> TURN_LEFT, 10 -> TURN_RIGHT, 11 -> STOP.
  - The phase counter is cleared.
- TURN_LEFT / TURN_RIGHT / TURN_STRAIGHT:
  - Phase counter increments.
  - Exit to STRAIGHT only when phase >= TURN_MIN and P=010.
  - Other patterns keep the mode.
  - Entry from 100/001 also clears phase.
- STOP and ERROR: terminal. A start pulse -> START and clears node_cnt.
- Simultaneous events:
  - The loss timeout beats a pattern change.
  - start is ignored in every mode except IDLE/STOP/ERROR.

Test Plan (FILTER_LEN=4, START_DELAY=20, LOST_LEN=30, TURN_MIN=8):
1. Release rst, sensor=010, start pulse.
   -> mode 0->1 (1 cycle) ->2 (20 cycles) ->3.
   -> lastMode=1 on the START->COUNT edge and =2 on the COUNT->STRAIGHT edge, 0 elsewhere.
2. In STRAIGHT, sensor toggles 110/010 every 2 cycles.
   -> mode stays 3 (filter rejects).
   -> Then 110 held 4 cycles -> mode 8; 011 held -> mode 9.
3. Sensor=111 held, route=01, then sensor=100.
   -> mode 4, node_cnt 0->1.
   -> On leaving 111 -> mode 6.
   -> Sensor 010 at phase 3 -> still 6; at phase >= 8 -> 3, with lastMode=6 for exactly one cycle.
4. Intersection with route=11.
   -> CHOOSE -> STOP(30), held regardless of sensor.
   -> Start pulse -> START, node_cnt=0.
5. In STRAIGHT, sensor=000 for 40 cycles.
   -> mode 3 held until the lost counter reaches 30 -> mode 31.
   -> Also: 000 for 20 cycles then 010 -> no ERROR, counter cleared.
6. Assert rst=0 mid-TURN_RIGHT.
   -> Immediately mode=0, lastMode=0, node_cnt=0.
   -> After release, only a start pulse leaves IDLE.
   -> 16 intersections -> node_cnt wraps to 0.
